// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Two requesters share one 8-bit left barrel shifter (3-bit amount). A
//   round-robin arbiter picks a job in IDLE. The job is applied in passes of
//   at most 7 bit positions in SHIFT. The result is held in DONE until the
//   consumer takes it.
//
// Ports
//   clk                     : clock, all state updates on the rising edge
//   rst_n                   : synchronous active-low reset
//   req0_valid / req1_valid : requester has a shift job pending
//   req0_ready / req1_ready : job accepted this cycle (combinational grant)
//   req0_data  / req1_data  : 8-bit operand to shift left
//   req0_sh    / req1_sh    : shift amount 0..15
//   res_valid               : result available (held until res_ready)
//   res_ready               : consumer accepts the result
//   res_data                : shifted operand
//   res_id                  : requester that owns res_data
//   busy                    : job in progress (SHIFT or DONE)
module shift_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [7:0] req0_data,
    input  logic [7:0] req1_data,
    input  logic [3:0] req0_sh,
    input  logic [3:0] req1_sh,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_id,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     state_q;
    logic       ptr_q;
    logic [7:0] acc_q;
    logic [3:0] rem_q;
    logic       id_q;
    logic       res_valid_q;
    logic       busy_q;

    logic [2:0] step_d;
    logic [7:0] acc_d;
    logic [3:0] rem_d;
    logic       gnt0;
    logic       gnt1;

    // Log-stage left shifter, zero fill, truncated to 8 bits.
    function automatic logic [7:0] barrel_shl(input logic [7:0] x, input logic [2:0] amt);
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s4;
        s1 = amt[0] ? {x[6:0],  1'b0}  : x;
        s2 = amt[1] ? {s1[5:0], 2'b00} : s1;
        s4 = amt[2] ? {s2[3:0], 4'h0}  : s2;
        return s4;
    endfunction

    always_comb begin
        step_d = (rem_q > 4'd7) ? 3'd7 : rem_q[2:0];
        acc_d  = barrel_shl(acc_q, step_d);
        rem_d  = rem_q - {1'b0, step_d};
    end

    // Grant: a lone valid wins, on contention ptr decides. Gated by rst_n so
    // neither ready rises while reset is asserted.
    always_comb begin
        gnt0 = rst_n && (state_q == S_IDLE) && req0_valid && (!req1_valid || !ptr_q);
        gnt1 = rst_n && (state_q == S_IDLE) && req1_valid && (!req0_valid ||  ptr_q);
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign res_valid  = res_valid_q;
    assign res_data   = acc_q;
    assign res_id     = id_q;
    assign busy       = busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= 1'b0;
            acc_q       <= 8'h00;
            rem_q       <= 4'd0;
            id_q        <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt0) begin
                        acc_q   <= req0_data;
                        rem_q   <= req0_sh;
                        id_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end else if (gnt1) begin
                        acc_q   <= req1_data;
                        rem_q   <= req1_sh;
                        id_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // A zero shift still spends one pass here with step 0.
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    if (rem_d == 4'd0) begin
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        ptr_q       <= ~id_q;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed testbench for shift_arbiter: reset state, single- and two-pass
// jobs, backpressure with input changes after accept, mid-job reset, and
// round-robin contention.
module tb_shift_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic       req1_valid;
    logic       req0_ready;
    logic       req1_ready;
    logic [7:0] req0_data;
    logic [7:0] req1_data;
    logic [3:0] req0_sh;
    logic [3:0] req1_sh;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_id;
    logic       busy;

    int n_cmp;
    int n_err;

    shift_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_data  (req0_data),
        .req1_data  (req1_data),
        .req0_sh    (req0_sh),
        .req1_sh    (req1_sh),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_out(input string tag);
        check({tag, ".res_valid"}, {31'd0, res_valid}, 32'd0);
        check({tag, ".busy"},      {31'd0, busy},      32'd0);
    endtask

    task automatic check_result(input string tag, input logic [7:0] d, input logic id);
        check({tag, ".res_valid"}, {31'd0, res_valid}, 32'd1);
        check({tag, ".res_data"},  {24'd0, res_data},  {24'd0, d});
        check({tag, ".res_id"},    {31'd0, res_id},    {31'd0, id});
        check({tag, ".busy"},      {31'd0, busy},      32'd1);
    endtask

    task automatic check_ready(input string tag, input logic r0, input logic r1);
        check({tag, ".req0_ready"}, {31'd0, req0_ready}, {31'd0, r0});
        check({tag, ".req1_ready"}, {31'd0, req1_ready}, {31'd0, r1});
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 8'h00;
        req1_data  = 8'h00;
        req0_sh    = 4'd0;
        req1_sh    = 4'd0;
        res_ready  = 1'b1;

        // Reset state; readies held low under reset even with valids high
        tick();
        tick();
        check_idle_out("rst");
        check("rst.res_data", {24'd0, res_data}, 32'h00);
        check("rst.res_id",   {31'd0, res_id},   32'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_ready("rst", 1'b0, 1'b0);
        req1_valid = 1'b0;

        // Single job: req0 0x81 << 3 = 0x08, result at N+2
        rst_n     = 1'b1;
        req0_data = 8'h81;
        req0_sh   = 4'd3;
        #1;
        check_ready("j1.acc", 1'b1, 1'b0);
        tick();                                  // N+1
        req0_valid = 1'b0;
        #1;
        check("j1.n1.res_valid", {31'd0, res_valid}, 32'd0);
        check("j1.n1.busy",      {31'd0, busy},      32'd1);
        check_ready("j1.n1", 1'b0, 1'b0);
        tick();                                  // N+2
        check_result("j1.n2", 8'h08, 1'b0);
        tick();                                  // handoff done, IDLE
        check_idle_out("j1.idle");

        // Two-pass job: req1 0xFF << 9 = 0x00, result at N+3
        req1_valid = 1'b1;
        req1_data  = 8'hFF;
        req1_sh    = 4'd9;
        #1;
        check_ready("j2.acc", 1'b0, 1'b1);
        tick();
        req1_valid = 1'b0;
        #1;
        check("j2.n1.res_valid", {31'd0, res_valid}, 32'd0);
        tick();
        check("j2.n2.res_valid", {31'd0, res_valid}, 32'd0);
        check("j2.n2.busy",      {31'd0, busy},      32'd1);
        tick();
        check_result("j2.n3", 8'h00, 1'b1);
        tick();
        check_idle_out("j2.idle");

        // Zero shift: one pass, result 0x01 at N+2
        req1_valid = 1'b1;
        req1_data  = 8'h01;
        req1_sh    = 4'd0;
        #1;
        check_ready("j3.acc", 1'b0, 1'b1);
        tick();
        req1_valid = 1'b0;
        #1;
        check("j3.n1.res_valid", {31'd0, res_valid}, 32'd0);
        tick();
        check_result("j3.n2", 8'h01, 1'b1);
        tick();
        check_idle_out("j3.idle");

        // Input change after accept plus backpressure: 0x0F << 4 = 0xF0
        res_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h0F;
        req0_sh    = 4'd4;
        #1;
        check_ready("j4.acc", 1'b1, 1'b0);
        tick();
        req0_data  = 8'hF0;
        req0_sh    = 4'd1;
        req1_valid = 1'b1;
        #1;
        check_ready("j4.n1", 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_result("j4.hold", 8'hF0, 1'b0);
            check_ready("j4.hold", 1'b0, 1'b0);
            tick();
        end
        check_result("j4.hold_end", 8'hF0, 1'b0);
        res_ready = 1'b1;
        #1;
        tick();                                  // handoff edge
        // Next accept available right away; ptr now favours req1
        check_idle_out("j4.idle");
        check_ready("j4.next", 1'b0, 1'b1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;

        // Mid-job reset during SHIFT of a sh=12 job
        req0_valid = 1'b1;
        req0_data  = 8'hAA;
        req0_sh    = 4'd12;
        #1;
        check_ready("j5.acc", 1'b1, 1'b0);
        tick();                                  // SHIFT, first pass
        check("j5.n1.busy", {31'd0, busy}, 32'd1);
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 8'h01;
        req1_data  = 8'h02;
        req0_sh    = 4'd1;
        req1_sh    = 4'd1;
        tick();
        check_idle_out("j5.rst");
        check("j5.rst.res_data", {24'd0, res_data}, 32'h00);
        check_ready("j5.rst", 1'b0, 1'b0);
        tick();
        check_idle_out("j5.rst2");

        // Contention from reset: req0 first, then alternate
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_ready("rr.acc", (k % 2) == 0, (k % 2) == 1);
            tick();                              // SHIFT
            check("rr.shift.res_valid", {31'd0, res_valid}, 32'd0);
            tick();                              // DONE
            check_result("rr.done", ((k % 2) == 0) ? 8'h02 : 8'h04, (k % 2) == 1);
            tick();                              // back to IDLE
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check_idle_out("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog against a stuck stimulus sequence.
    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached before end of sequence");
        $fatal(1, "timeout");
    end

endmodule
